icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the IF stage and the backing instruction memory.
- Serves 32-bit instruction words to fetch with a combinational hit path.
- On a miss, asserts the miss flag consumed by the stall unit (Imiss path) and refills one full line, word by word, over a req/ack handshake.
- A single-cycle invalidate input supports self-modifying-code and program-load flushes.

---
 rtl/icache_dm_pkg.sv | 24 ++
 rtl/icache_refill_fsm.sv | 118 +++++++++++
 rtl/icache_dm.sv | 110 +++++++++++
 tb/tb_icache_dm.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// controller state encodings and address-field width helpers.
package icache_dm_pkg;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REFILL = 2'd1,
    IC_COMMIT = 2'd2
  } ic_state_e;

  // Byte-offset width: 2 byte-select bits plus the word-select bits.
  function automatic int ic_off_w(input int words_per_line);
    return 2 + $clog2(words_per_line);
  endfunction

  function automatic int ic_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int ic_tag_w(input int addr_w, input int lines, input int words_per_line);
    return addr_w - ic_off_w(words_per_line) - ic_idx_w(lines);
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line-refill controller: latches the missing line, walks its words over the
// req/ack memory handshake, then commits the line (tracking invalidates seen meanwhile).
module icache_refill_fsm
  import icache_dm_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              i_start,
  input  logic [ADDR_W-1:0]                 i_line_addr,
  input  logic                              i_inval,
  input  logic                              i_mem_ack,
  output ic_state_e                         o_state,
  output logic [$clog2(WORDS_PER_LINE)-1:0] o_cnt,
  output logic [ADDR_W-1:0]                 o_base,
  output logic                              o_mem_req,
  output logic [ADDR_W-1:0]                 o_mem_addr,
  output logic                              o_data_we,
  output logic                              o_commit_set
);

  localparam int OFF_W = ic_off_w(WORDS_PER_LINE);
  localparam int WRD_W = $clog2(WORDS_PER_LINE);
  localparam logic [WRD_W-1:0] CNT_ONE  = WRD_W'(1);
  localparam logic [WRD_W-1:0] CNT_LAST = WRD_W'(WORDS_PER_LINE - 1);

  ic_state_e         state_q, state_d;
  logic [WRD_W-1:0]  cnt_q, cnt_d, cnt_nxt;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              pend_q, pend_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign cnt_nxt = cnt_q + CNT_ONE;

  // Next-state, counter and handshake computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    pend_d  = pend_q;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      IC_IDLE: begin
        pend_d = 1'b0;
        if (i_start) begin
          state_d = IC_REFILL;
          base_d  = i_line_addr;
          cnt_d   = '0;
          req_d   = 1'b1;
          addr_d  = i_line_addr;
        end else begin
          state_d = IC_IDLE;
        end
      end
      IC_REFILL: begin
        if (i_inval) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (i_mem_ack) begin
          cnt_d = cnt_nxt;
          // Request stays up across back-to-back acks; drop it only after the last word.
          if (cnt_q == CNT_LAST) begin
            state_d = IC_COMMIT;
            req_d   = 1'b0;
          end else begin
            addr_d = {base_q[ADDR_W-1:OFF_W], cnt_nxt, 2'b00};
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      IC_COMMIT: begin
        pend_d  = 1'b0;
        state_d = IC_IDLE;
      end
      default: begin
        state_d = IC_IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IC_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      pend_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign o_state      = state_q;
  assign o_cnt        = cnt_q;
  assign o_base       = base_q;
  assign o_mem_req    = req_q;
  assign o_mem_addr   = addr_q;
  assign o_data_we    = (state_q == IC_REFILL) & i_mem_ack;
  assign o_commit_set = (state_q == IC_COMMIT) & ~pend_q & ~i_inval;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: tag/data arrays, combinational
// hit path to fetch, and a refill controller toward the backing memory.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_inval,
  output logic [31:0]       o_instr,
  output logic              o_miss,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_data
);

  localparam int OFF_W = ic_off_w(WORDS_PER_LINE);
  localparam int IDX_W = ic_idx_w(LINES);
  localparam int TAG_W = ic_tag_w(ADDR_W, LINES, WORDS_PER_LINE);
  localparam int WRD_W = $clog2(WORDS_PER_LINE);

  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [31:0]            data_mem [LINES*WORDS_PER_LINE];

  ic_state_e              state_s;
  logic [WRD_W-1:0]       cnt_s;
  logic [ADDR_W-1:0]      base_s;
  logic                   data_we_s;
  logic                   commit_set_s;

  logic [IDX_W-1:0]       req_idx_s, fill_idx_s;
  logic [TAG_W-1:0]       req_tag_s, fill_tag_s;
  logic [WRD_W-1:0]       req_word_s;
  logic [ADDR_W-1:0]      line_addr_s;
  logic                   lookup_hit_s, hit_s;
  logic                   unused_bits;

  assign req_idx_s   = i_addr[OFF_W +: IDX_W];
  assign req_tag_s   = i_addr[ADDR_W-1 -: TAG_W];
  assign req_word_s  = i_addr[2 +: WRD_W];
  assign line_addr_s = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign fill_idx_s  = base_s[OFF_W +: IDX_W];
  assign fill_tag_s  = base_s[ADDR_W-1 -: TAG_W];
  assign unused_bits = ^{i_addr[1:0], base_s[OFF_W-1:0]};

  // Lookup ignores the controller state; the hit seen by fetch is only honoured in IDLE.
  assign lookup_hit_s = valid_q[req_idx_s] & (tag_mem[req_idx_s] == req_tag_s);
  assign hit_s        = lookup_hit_s & (state_s == IC_IDLE);

  assign o_miss  = (i_req & ~hit_s) | (state_s != IC_IDLE);
  assign o_instr = hit_s ? data_mem[{req_idx_s, req_word_s}] : 32'h0000_0000;

  icache_refill_fsm #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .ADDR_W         (ADDR_W)
  ) u_refill (
    .Clk          (Clk),
    .Rst          (Rst),
    .i_start      (i_req & ~lookup_hit_s),
    .i_line_addr  (line_addr_s),
    .i_inval      (i_inval),
    .i_mem_ack    (i_mem_ack),
    .o_state      (state_s),
    .o_cnt        (cnt_s),
    .o_base       (base_s),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .o_data_we    (data_we_s),
    .o_commit_set (commit_set_s)
  );

  // Valid-bit update: a flush wins; the line in flight is kept out by the pending flag.
  always_comb begin
    valid_d = valid_q;
    if (i_inval) begin
      valid_d = '0;
    end else if (commit_set_s) begin
      valid_d[fill_idx_s] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only array state that reset clears.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays: synchronous write, no reset.
  always_ff @(posedge Clk) begin
    if (data_we_s) begin
      data_mem[{fill_idx_s, cnt_s}] <= i_mem_data;
    end
    if (commit_set_s) begin
      tag_mem[fill_idx_s] <= fill_tag_s;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm: miss/refill, eviction,
// slow memory, invalidate, reset mid-refill and stray acks.
module tb_icache_dm;

  logic        Clk;
  logic        Rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_inval;
  logic [31:0] o_instr;
  logic        o_miss;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;

  int          n_checks;
  int          n_fail;
  logic [31:0] obs_addr [4];
  int          miss_cyc;
  int          unstable;
  int          req_drop;
  bit          timeout;

  icache_dm #(.LINES(16), .WORDS_PER_LINE(4), .ADDR_W(32)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_inval    (i_inval),
    .o_instr    (o_instr),
    .o_miss     (o_miss),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_ack  (i_mem_ack),
    .i_mem_data (i_mem_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic probe(input logic [31:0] a);
    tick();
    i_addr = a;
    i_req  = 1'b1;
    @(negedge Clk);
  endtask

  // Memory model: serves one line refill starting at the current cycle (miss presented),
  // ends at the negedge of the cycle where the first hit is expected.
  task automatic serve(input logic [31:0] dbase, input int gap, input int inval_at,
                       input bit extra_ack, input bit wander);
    logic [31:0] save_addr;
    logic        save_req;
    logic [31:0] last_addr;
    bit          have_last;
    bit          inv_done;
    int          words;
    int          waitc;
    int          post;
    save_addr = i_addr;
    save_req  = i_req;
    last_addr = 32'h0;
    have_last = 1'b0;
    inv_done  = 1'b0;
    words = 0; waitc = 0; post = 0;
    miss_cyc = 0; unstable = 0; req_drop = 0; timeout = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      i_mem_ack = 1'b0;
      i_inval   = 1'b0;
      if (words == 4) post++;
      if (post == 1) begin
        i_addr = save_addr;
        i_req  = save_req;
        if (extra_ack) begin
          i_mem_ack  = 1'b1;
          i_mem_data = 32'hBAD0_0000;
        end
      end
      if (words > 0 && words < 4 && !o_mem_req) req_drop++;
      if (o_mem_req && words < 4) begin
        if (wander) begin
          i_addr = 32'h0000_02C0;
          i_req  = 1'b0;
        end
        if (words == inval_at && !inv_done) begin
          i_inval  = 1'b1;
          inv_done = 1'b1;
        end
        if (have_last && o_mem_addr !== last_addr) unstable++;
        if (waitc == gap) begin
          i_mem_ack       = 1'b1;
          i_mem_data      = dbase + 32'(words);
          obs_addr[words] = o_mem_addr;
          words++;
          waitc     = 0;
          have_last = 1'b0;
        end else begin
          waitc++;
          last_addr = o_mem_addr;
          have_last = 1'b1;
        end
      end
      @(negedge Clk);
      if (o_miss) miss_cyc++;
      if (post == 2) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
    i_mem_ack = 1'b0;
    i_inval   = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0040; i_inval = 1'b0;
    i_mem_ack = 1'b0; i_mem_data = 32'h0;
    #2;
    n_checks++; if (o_miss !== 1'b1) begin n_fail++; $display("FAIL rst_miss: got %b expected 1", o_miss); end
    n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", o_mem_req); end
    n_checks++; if (o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 0", o_mem_addr); end
    n_checks++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h expected 0", o_instr); end
    i_req = 1'b0;
    #1;
    n_checks++; if (o_miss !== 1'b0) begin n_fail++; $display("FAIL rst_noreq_miss: got %b expected 0", o_miss); end
    tick();
    Rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    tick();
    i_addr = 32'h0000_0040; i_req = 1'b1;
    serve(32'h0000_00A0, 0, -1, 1'b0, 1'b0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL cold_timeout: refill did not complete"); end
    n_checks++; if (miss_cyc !== 6) begin n_fail++; $display("FAIL cold_miss_cycles: got %0d expected 6", miss_cyc); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_addr[i] !== 32'h40 + 32'(4 * i)) begin
        n_fail++; $display("FAIL cold_mem_addr%0d: got %h expected %h", i, obs_addr[i], 32'h40 + 32'(4 * i));
      end
    end
    n_checks++; if (o_instr !== 32'h0000_00A0) begin n_fail++; $display("FAIL cold_instr: got %h expected 000000a0", o_instr); end
    probe(32'h0000_004C);
    n_checks++; if (o_miss !== 1'b0) begin n_fail++; $display("FAIL cold_4c_miss: got %b expected 0", o_miss); end
    n_checks++; if (o_instr !== 32'h0000_00A3) begin n_fail++; $display("FAIL cold_4c_instr: got %h expected 000000a3", o_instr); end
    probe(32'h0000_0044);
    n_checks++; if (o_instr !== 32'h0000_00A1) begin n_fail++; $display("FAIL cold_44_instr: got %h expected 000000a1", o_instr); end
    i_req = 1'b0;
  endtask

  task automatic test_conflict();
    tick();
    i_addr = 32'h0000_0440; i_req = 1'b1;
    serve(32'h0000_00B0, 0, -1, 1'b0, 1'b0);
    n_checks++; if (miss_cyc !== 6) begin n_fail++; $display("FAIL evict_miss_cycles: got %0d expected 6", miss_cyc); end
    n_checks++; if (obs_addr[0] !== 32'h440) begin n_fail++; $display("FAIL evict_addr0: got %h expected 00000440", obs_addr[0]); end
    n_checks++; if (obs_addr[3] !== 32'h44C) begin n_fail++; $display("FAIL evict_addr3: got %h expected 0000044c", obs_addr[3]); end
    n_checks++; if (o_instr !== 32'h0000_00B0) begin n_fail++; $display("FAIL evict_instr: got %h expected 000000b0", o_instr); end
    probe(32'h0000_0040);
    n_checks++; if (o_miss !== 1'b1) begin n_fail++; $display("FAIL evict_old_miss: got %b expected 1", o_miss); end
    i_req = 1'b0;
    tick();
    i_addr = 32'h0000_0040; i_req = 1'b1;
    serve(32'h0000_00A0, 0, -1, 1'b0, 1'b0);
    n_checks++; if (o_instr !== 32'h0000_00A0) begin n_fail++; $display("FAIL evict_refill_instr: got %h expected 000000a0", o_instr); end
    probe(32'h0000_0440);
    n_checks++; if (o_miss !== 1'b1) begin n_fail++; $display("FAIL evict_new_miss: got %b expected 1", o_miss); end
    i_req = 1'b0;
  endtask

  task automatic test_slow_memory();
    tick();
    i_addr = 32'h0000_0100; i_req = 1'b1;
    serve(32'h0000_00D0, 3, -1, 1'b1, 1'b1);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL slow_timeout: refill did not complete"); end
    n_checks++; if (miss_cyc !== 18) begin n_fail++; $display("FAIL slow_miss_cycles: got %0d expected 18", miss_cyc); end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL slow_addr_stable: got %0d changes expected 0", unstable); end
    n_checks++; if (req_drop !== 0) begin n_fail++; $display("FAIL slow_req_held: got %0d drops expected 0", req_drop); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_addr[i] !== 32'h100 + 32'(4 * i)) begin
        n_fail++; $display("FAIL slow_mem_addr%0d: got %h expected %h", i, obs_addr[i], 32'h100 + 32'(4 * i));
      end
    end
    n_checks++; if (o_instr !== 32'h0000_00D0) begin n_fail++; $display("FAIL slow_instr0: got %h expected 000000d0", o_instr); end
    probe(32'h0000_0108);
    n_checks++; if (o_instr !== 32'h0000_00D2) begin n_fail++; $display("FAIL slow_instr2: got %h expected 000000d2", o_instr); end
    probe(32'h0000_010C);
    n_checks++; if (o_instr !== 32'h0000_00D3) begin n_fail++; $display("FAIL slow_instr3: got %h expected 000000d3", o_instr); end
    i_req = 1'b0;
  endtask

  task automatic test_invalidate();
    probe(32'h0000_0040);
    n_checks++; if (o_miss !== 1'b0) begin n_fail++; $display("FAIL inval_pre_hit: got %b expected 0", o_miss); end
    tick();
    i_req = 1'b0; i_inval = 1'b1;
    tick();
    i_inval = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0040;
    @(negedge Clk);
    n_checks++; if (o_miss !== 1'b1) begin n_fail++; $display("FAIL inval_idle_miss: got %b expected 1", o_miss); end
    i_req = 1'b0;
    tick();
    i_req = 1'b1; i_addr = 32'h0000_0040;
    serve(32'h0000_00E0, 0, 1, 1'b0, 1'b0);
    n_checks++; if (miss_cyc !== 7) begin n_fail++; $display("FAIL inval_refill_miss_cycles: got %0d expected 7", miss_cyc); end
    n_checks++; if (o_miss !== 1'b1) begin n_fail++; $display("FAIL inval_refill_still_miss: got %b expected 1", o_miss); end
    n_checks++; if (obs_addr[3] !== 32'h4C) begin n_fail++; $display("FAIL inval_refill_done: got %h expected 0000004c", obs_addr[3]); end
    i_req = 1'b0;
    tick();
    i_req = 1'b1;
    serve(32'h0000_00E0, 0, -1, 1'b0, 1'b0);
    n_checks++; if (miss_cyc !== 6) begin n_fail++; $display("FAIL inval_rerefill_cycles: got %0d expected 6", miss_cyc); end
    n_checks++; if (o_instr !== 32'h0000_00E0) begin n_fail++; $display("FAIL inval_rerefill_instr: got %h expected 000000e0", o_instr); end
    i_req = 1'b0;
  endtask

  task automatic test_reset_mid_refill();
    tick();
    i_addr = 32'h0000_0440; i_req = 1'b1;
    @(negedge Clk);
    n_checks++; if (o_miss !== 1'b1) begin n_fail++; $display("FAIL rmid_start_miss: got %b expected 1", o_miss); end
    tick();
    i_mem_ack = 1'b1; i_mem_data = 32'h0000_00F0;
    @(negedge Clk);
    n_checks++; if (o_mem_addr !== 32'h440) begin n_fail++; $display("FAIL rmid_addr0: got %h expected 00000440", o_mem_addr); end
    tick();
    i_mem_data = 32'h0000_00F1;
    tick();
    i_mem_ack = 1'b0;
    #1;
    Rst = 1'b0;
    #1;
    n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_req: got %b expected 0", o_mem_req); end
    n_checks++; if (o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_mem_addr: got %h expected 0", o_mem_addr); end
    n_checks++; if (o_instr !== 32'h0) begin n_fail++; $display("FAIL rmid_instr: got %h expected 0", o_instr); end
    i_addr = 32'h0000_0040;
    #1;
    n_checks++; if (o_miss !== 1'b1) begin n_fail++; $display("FAIL rmid_valid_cleared: got %b expected 1", o_miss); end
    tick();
    Rst = 1'b1;
    serve(32'h0000_00C0, 0, -1, 1'b0, 1'b0);
    n_checks++; if (obs_addr[0] !== 32'h40) begin n_fail++; $display("FAIL rmid_restart_addr: got %h expected 00000040", obs_addr[0]); end
    n_checks++; if (miss_cyc !== 6) begin n_fail++; $display("FAIL rmid_restart_cycles: got %0d expected 6", miss_cyc); end
    n_checks++; if (o_instr !== 32'h0000_00C0) begin n_fail++; $display("FAIL rmid_instr0: got %h expected 000000c0", o_instr); end
    probe(32'h0000_0044);
    n_checks++; if (o_instr !== 32'h0000_00C1) begin n_fail++; $display("FAIL rmid_instr1: got %h expected 000000c1", o_instr); end
    i_req = 1'b0;
  endtask

  task automatic test_stray_ack();
    tick();
    i_addr = 32'h0000_0040; i_req = 1'b0;
    i_mem_ack = 1'b1; i_mem_data = 32'hDEAD_BEEF;
    tick();
    tick();
    i_mem_ack = 1'b0; i_req = 1'b1;
    @(negedge Clk);
    n_checks++; if (o_miss !== 1'b0) begin n_fail++; $display("FAIL stray_miss: got %b expected 0", o_miss); end
    n_checks++; if (o_instr !== 32'h0000_00C0) begin n_fail++; $display("FAIL stray_instr0: got %h expected 000000c0", o_instr); end
    n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL stray_mem_req: got %b expected 0", o_mem_req); end
    probe(32'h0000_0044);
    n_checks++; if (o_instr !== 32'h0000_00C1) begin n_fail++; $display("FAIL stray_instr1: got %h expected 000000c1", o_instr); end
    i_req = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_slow_memory();
    test_invalidate();
    test_reset_mid_refill();
    test_stray_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
